// File: rtl/phase_track_pkg.sv
// Shared types and helpers for the phase-tracking NCO controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package phase_track_pkg;

    localparam int PHASE_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DELAY    = 3'd1,
        START    = 3'd2,
        WAIT_ACT = 3'd3,
        RUN      = 3'd4,
        CHECK    = 3'd5
    } state_t;

    // Magnitude of a two's-complement value. The most negative value maps
    // to itself, which as an unsigned number is still the correct magnitude.
    function automatic logic [PHASE_W-1:0] abs_s32(input logic [PHASE_W-1:0] v);
        return v[PHASE_W-1] ? (~v + PHASE_W'(1)) : v;
    endfunction

endpackage

// File: rtl/phase_accum.sv
// Phase accumulator register: acc <= acc + inc every clock, silent wrap mod 2^32.
// Latency: 1 cycle from inc_i to acc_o.
// Backpressure: none; free-running.
// Ports: clk/rst (async active-high), inc_i increment, acc_o accumulated phase.
module phase_accum
    import phase_track_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] inc_i,
    output logic [PHASE_W-1:0] acc_o
);

    logic [PHASE_W-1:0] acc_q;
    logic [PHASE_W-1:0] acc_d;

    assign acc_d = acc_q + inc_i;
    assign acc_o = acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/phase_track_ctrl.sv
// NCO controller that sequences one phase adjustment and reports residual error.
// Latency: adj_start N+delay_time+1 after request; done one cycle after CHECK.
// Backpressure: requests outside IDLE are dropped; freq writes outside IDLE are deferred.
// Ports: freq/freq_valid load the increment; adj_req/desired_phase/delay_time/work_time
// start an adjustment; freq_add/adj_active/adj_ready come from the adjuster;
// phase/ref_phase are the two accumulators; the rest report adjustment status.
module phase_track_ctrl
    import phase_track_pkg::*;
#(
    parameter int unsigned        ACT_TIMEOUT = 16,
    parameter logic [PHASE_W-1:0] ERR_TOL     = 32'h0010_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PHASE_W-1:0] freq,
    input  logic               freq_valid,
    input  logic               adj_req,
    input  logic [PHASE_W-1:0] desired_phase,
    input  logic [31:0]        delay_time,
    input  logic [31:0]        work_time,
    input  logic [PHASE_W-1:0] freq_add,
    input  logic               adj_active,
    input  logic               adj_ready,
    output logic [PHASE_W-1:0] phase,
    output logic [PHASE_W-1:0] ref_phase,
    output logic [PHASE_W-1:0] current_phase,
    output logic [PHASE_W-1:0] target_phase,
    output logic [31:0]        work_time_o,
    output logic               adj_start,
    output logic               busy,
    output logic               done,
    output logic               adj_err,
    output logic [PHASE_W-1:0] phase_err,
    output logic               within_tol
);

    localparam int unsigned TCNT_W = $clog2(ACT_TIMEOUT) + 1;

    state_t              state_q, state_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d, tcnt_inc;
    logic [PHASE_W-1:0]  freq_q, freq_d;
    logic [PHASE_W-1:0]  pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic [PHASE_W-1:0]  target_q, target_d;
    logic [31:0]         work_q, work_d;
    logic [PHASE_W-1:0]  cur_q, cur_d;
    logic [PHASE_W-1:0]  err_q, err_d;
    logic                tol_q, tol_d;
    logic                done_q, done_d;
    logic                adj_err_q, adj_err_d;

    logic [PHASE_W-1:0]  offset;
    logic [PHASE_W-1:0]  phase_inc;
    logic                add_en;

    // Adjuster addend only counts while it is actually running for us.
    assign add_en    = adj_active && (state_q == WAIT_ACT || state_q == RUN);
    assign phase_inc = freq_q + (add_en ? freq_add : '0);
    assign offset    = phase - ref_phase;
    assign tcnt_inc  = tcnt_q + TCNT_W'(1);

    phase_accum u_ref_acc (
        .clk   (clk),
        .rst   (reset),
        .inc_i (freq_q),
        .acc_o (ref_phase)
    );

    phase_accum u_phase_acc (
        .clk   (clk),
        .rst   (reset),
        .inc_i (phase_inc),
        .acc_o (phase)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tcnt_d     = tcnt_q;
        freq_d     = freq_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        target_d   = target_q;
        work_d     = work_q;
        cur_d      = cur_q;
        err_d      = err_q;
        tol_d      = tol_q;
        done_d     = 1'b0;
        adj_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (adj_req) begin
                    target_d = desired_phase;
                    work_d   = work_time;
                    cnt_d    = delay_time;
                    state_d  = (delay_time == '0) ? START : DELAY;
                end
            end
            DELAY: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) begin
                    state_d = START;
                end
            end
            START: begin
                cur_d   = offset;
                tcnt_d  = '0;
                state_d = WAIT_ACT;
            end
            WAIT_ACT: begin
                if (adj_active) begin
                    state_d = RUN;
                end else begin
                    tcnt_d = tcnt_inc;
                    // Registered pulse lands ACT_TIMEOUT cycles after adj_start.
                    if (tcnt_inc == TCNT_W'(ACT_TIMEOUT - 1)) begin
                        adj_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            RUN: begin
                if (!adj_active || adj_ready) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                err_d   = target_q - offset;
                tol_d   = (abs_s32(err_d) <= ERR_TOL);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frequency changes never disturb an adjustment in flight; a write made
        // mid-adjustment is parked and committed on the edge that returns to IDLE.
        if (state_q == IDLE) begin
            if (freq_valid) begin
                freq_d = freq;
            end
        end else begin
            if (freq_valid) begin
                pend_d     = freq;
                pend_vld_d = 1'b1;
            end
            if (state_d == IDLE) begin
                if (freq_valid) begin
                    freq_d = freq;
                end else if (pend_vld_q) begin
                    freq_d = pend_q;
                end
                pend_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            freq_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            target_q   <= '0;
            work_q     <= '0;
            cur_q      <= '0;
            err_q      <= '0;
            tol_q      <= 1'b0;
            done_q     <= 1'b0;
            adj_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tcnt_q     <= tcnt_d;
            freq_q     <= freq_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            target_q   <= target_d;
            work_q     <= work_d;
            cur_q      <= cur_d;
            err_q      <= err_d;
            tol_q      <= tol_d;
            done_q     <= done_d;
            adj_err_q  <= adj_err_d;
        end
    end

    assign current_phase = cur_q;
    assign target_phase  = target_q;
    assign work_time_o   = work_q;
    assign adj_start     = (state_q == START);
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign adj_err       = adj_err_q;
    assign phase_err     = err_q;
    assign within_tol    = tol_q;

endmodule
